// File: rtl/fpnew_ordered_arbiter.sv
// Reorders results from parallel FP units back into dispatch order.
// A small index FIFO records which unit received each operation; only the oldest unit's result is accepted.
module fpnew_ordered_arbiter #(
   parameter int unsigned NumIn    = 5,
   parameter int unsigned Width    = 64,
   parameter int unsigned TagWidth = 1,
   parameter int unsigned Depth    = 4,
   parameter int unsigned OutReg   = 1,
   localparam int unsigned IdxW    = (NumIn > 1) ? $clog2(NumIn) : 1,
   localparam int unsigned CntW    = $clog2(Depth + 1)
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               flush_i,
   input  logic                               issue_valid_i,
   input  logic [IdxW-1:0]                    issue_idx_i,
   output logic                               issue_ready_o,
   input  logic [NumIn-1:0]                   in_valid_i,
   output logic [NumIn-1:0]                   in_ready_o,
   input  logic [NumIn-1:0][Width-1:0]        in_result_i,
   input  logic [NumIn-1:0][4:0]              in_status_i,
   input  logic [NumIn-1:0][TagWidth-1:0]     in_tag_i,
   output logic                               out_valid_o,
   input  logic                               out_ready_i,
   output logic [Width-1:0]                   result_o,
   output logic [4:0]                         status_o,
   output logic [TagWidth-1:0]                tag_o,
   output logic                               busy_o,
   output logic [CntW-1:0]                    count_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [IdxW-1:0]     fifo_q [Depth];
   logic [PtrW-1:0]     wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [CntW-1:0]     count_q, count_d;
   logic [IdxW-1:0]     head;
   logic                notEmpty, outFree, push, pop;
   logic [NumIn-1:0]    headSel;
   logic [Width-1:0]    headResult;
   logic [4:0]          headStatus;
   logic [TagWidth-1:0] headTag;

   function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign notEmpty      = (count_q != '0);
   assign head          = fifo_q[rdPtr_q];
   assign issue_ready_o = (count_q < CntW'(Depth)) && !flush_i;
   assign push          = issue_valid_i && issue_ready_o;

   // One-hot head selection keeps an out-of-range index from addressing a missing unit.
   always_comb begin
      headSel = '0;
      for (int i = 0; i < int'(NumIn); i++) begin
         headSel[i] = notEmpty && (head == IdxW'(i));
      end
   end

   assign in_ready_o = (outFree && !flush_i) ? headSel : '0;
   assign pop        = |(in_valid_i & in_ready_o);

   always_comb begin
      headResult = '0;
      headStatus = '0;
      headTag    = '0;
      for (int i = 0; i < int'(NumIn); i++) begin
         if (headSel[i]) begin
            headResult = in_result_i[i];
            headStatus = in_status_i[i];
            headTag    = in_tag_i[i];
         end
      end
   end

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (flush_i) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (push) wrPtr_d = nextPtr(wrPtr_q);
         if (pop)  rdPtr_d = nextPtr(rdPtr_q);
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Index storage needs no reset: entries are only read while count says they are valid.
   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wrPtr_q] <= issue_idx_i;
   end

   if (OutReg != 0) begin : gen_out_reg
      logic                outValid_q;
      logic [Width-1:0]    result_q;
      logic [4:0]          status_q;
      logic [TagWidth-1:0] tag_q;

      assign outFree = !outValid_q || out_ready_i;

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            outValid_q <= 1'b0;
            result_q   <= '0;
            status_q   <= '0;
            tag_q      <= '0;
         end else if (flush_i) begin
            outValid_q <= 1'b0;
         end else if (pop) begin
            outValid_q <= 1'b1;
            result_q   <= headResult;
            status_q   <= headStatus;
            tag_q      <= headTag;
         end else if (out_ready_i) begin
            outValid_q <= 1'b0;
         end
      end

      assign out_valid_o = outValid_q;
      assign result_o    = result_q;
      assign status_o    = status_q;
      assign tag_o       = tag_q;
   end else begin : gen_pass
      assign outFree     = out_ready_i;
      assign out_valid_o = notEmpty && (|(in_valid_i & headSel)) && !flush_i;
      assign result_o    = headResult;
      assign status_o    = headStatus;
      assign tag_o       = headTag;
   end

   assign busy_o  = notEmpty || out_valid_o;
   assign count_o = count_q;

   issueIdxInRange: assert property (@(posedge clk_i) disable iff (rst_i)
      issue_valid_i |-> (int'(issue_idx_i) < int'(NumIn)));

endmodule

// File: tb/tb_fpnew_ordered_arbiter.sv
// Directed bench for fpnew_ordered_arbiter: a registered 5-unit instance and a
// pass-through single-unit instance with a non-power-of-two queue depth.
module tb_fpnew_ordered_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Main instance: defaults (NumIn=5, Width=64, TagWidth=1, Depth=4, OutReg=1)
   logic             flush, issueValid, issueReady, outValid, outReady, busy;
   logic [2:0]       issueIdx, count;
   logic [4:0]       inValid, inReady, status;
   logic [4:0][63:0] inResult;
   logic [4:0][4:0]  inStatus;
   logic [4:0][0:0]  inTag;
   logic [63:0]      result;
   logic [0:0]       tag;

   fpnew_ordered_arbiter dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .issue_valid_i(issueValid), .issue_idx_i(issueIdx), .issue_ready_o(issueReady),
      .in_valid_i(inValid), .in_ready_o(inReady),
      .in_result_i(inResult), .in_status_i(inStatus), .in_tag_i(inTag),
      .out_valid_o(outValid), .out_ready_i(outReady),
      .result_o(result), .status_o(status), .tag_o(tag),
      .busy_o(busy), .count_o(count)
   );

   // Pass-through instance: NumIn=1, Depth=3, OutReg=0
   logic             flush2, issueValid2, issueReady2, outValid2, outReady2, busy2;
   logic [0:0]       issueIdx2, inValid2, inReady2, tag2;
   logic [1:0]       count2;
   logic [0:0][15:0] inResult2;
   logic [0:0][4:0]  inStatus2;
   logic [0:0][0:0]  inTag2;
   logic [15:0]      result2;
   logic [4:0]       status2;

   fpnew_ordered_arbiter #(.NumIn(1), .Width(16), .TagWidth(1), .Depth(3), .OutReg(0)) dut2 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush2),
      .issue_valid_i(issueValid2), .issue_idx_i(issueIdx2), .issue_ready_o(issueReady2),
      .in_valid_i(inValid2), .in_ready_o(inReady2),
      .in_result_i(inResult2), .in_status_i(inStatus2), .in_tag_i(inTag2),
      .out_valid_o(outValid2), .out_ready_i(outReady2),
      .result_o(result2), .status_o(status2), .tag_o(tag2),
      .busy_o(busy2), .count_o(count2)
   );

   int testsRun = 0;
   int testsFailed = 0;

   task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [2:0] idx);
      issueValid = 1'b1;
      issueIdx   = idx;
      nextCycle();
      issueValid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0; issueValid = 1'b0; issueIdx = '0; inValid = '0; outReady = 1'b1;
      inResult = '0; inStatus = '0; inTag = '0;
      flush2 = 1'b0; issueValid2 = 1'b0; issueIdx2 = '0; inValid2 = '0; outReady2 = 1'b1;
      inResult2 = '0; inStatus2 = '0; inTag2 = '0;

      // Reset values
      #12;
      checkOutput("rst count", 64'(count), 64'd0);
      checkOutput("rst outValid", 64'(outValid), 64'd0);
      checkOutput("rst result", result, 64'd0);
      checkOutput("rst inReady", 64'(inReady), 64'd0);
      checkOutput("rst busy", 64'(busy), 64'd0);
      checkOutput("rst issueReady", 64'(issueReady), 64'd1);
      nextCycle();
      rst = 1'b0;

      // Ordering: dispatch 2,0,3; results arrive 3,0,2
      applyStimulus(3'd2);
      applyStimulus(3'd0);
      applyStimulus(3'd3);
      checkOutput("ord count3", 64'(count), 64'd3);
      checkOutput("ord busy", 64'(busy), 64'd1);
      inResult[3] = 64'h33; inTag[3] = 1'b1; inValid = 5'b01000;
      #1;
      checkOutput("ord stall3 ready", 64'(inReady), 64'b00100);
      nextCycle();
      checkOutput("ord stall3 count", 64'(count), 64'd3);
      checkOutput("ord stall3 outValid", 64'(outValid), 64'd0);
      inResult[0] = 64'hAA; inTag[0] = 1'b0; inValid = 5'b01001;
      nextCycle();
      checkOutput("ord stall0 count", 64'(count), 64'd3);
      inResult[2] = 64'h22; inTag[2] = 1'b1; inValid = 5'b01101;
      #1;
      checkOutput("ord head2 ready", 64'(inReady), 64'b00100);
      nextCycle();
      checkOutput("ord out2 valid", 64'(outValid), 64'd1);
      checkOutput("ord out2 result", result, 64'h22);
      checkOutput("ord out2 tag", 64'(tag), 64'd1);
      checkOutput("ord out2 count", 64'(count), 64'd2);
      inValid = 5'b01001;
      #1;
      checkOutput("ord head0 ready", 64'(inReady), 64'b00001);
      nextCycle();
      checkOutput("ord out0 result", result, 64'hAA);
      checkOutput("ord out0 tag", 64'(tag), 64'd0);
      inValid = 5'b01000;
      nextCycle();
      checkOutput("ord out3 result", result, 64'h33);
      checkOutput("ord out3 tag", 64'(tag), 64'd1);
      checkOutput("ord out3 count", 64'(count), 64'd0);
      inValid = '0;
      nextCycle();
      checkOutput("ord drain valid", 64'(outValid), 64'd0);
      checkOutput("ord drain busy", 64'(busy), 64'd0);

      // Full queue: push refused even with a same-cycle pop
      applyStimulus(3'd1);
      applyStimulus(3'd4);
      applyStimulus(3'd1);
      applyStimulus(3'd4);
      checkOutput("full count", 64'(count), 64'd4);
      checkOutput("full issueReady", 64'(issueReady), 64'd0);
      issueValid = 1'b1; issueIdx = 3'd2;
      inResult[1] = 64'h11; inValid = 5'b00010;
      #1;
      checkOutput("full head ready", 64'(inReady), 64'b00010);
      nextCycle();
      checkOutput("full pushpop count", 64'(count), 64'd3);
      checkOutput("full pop result", result, 64'h11);
      issueValid = 1'b0;

      // Backpressure: output held for 5 cycles with the head unit valid
      outReady = 1'b0;
      inResult[4] = 64'h44; inValid = 5'b10000;
      for (int i = 0; i < 5; i++) begin
         #1;
         checkOutput("bp valid", 64'(outValid), 64'd1);
         checkOutput("bp result", result, 64'h11);
         checkOutput("bp inReady", 64'(inReady), 64'd0);
         nextCycle();
      end
      checkOutput("bp count", 64'(count), 64'd3);
      outReady = 1'b1;
      inResult[1] = 64'h41; inValid = 5'b10010;
      nextCycle();
      checkOutput("bp rel1 result", result, 64'h44);
      checkOutput("bp rel1 count", 64'(count), 64'd2);
      inResult[4] = 64'h45;
      nextCycle();
      checkOutput("bp rel2 result", result, 64'h41);
      nextCycle();
      checkOutput("bp rel3 result", result, 64'h45);
      checkOutput("bp rel3 count", 64'(count), 64'd0);
      inValid = '0;
      nextCycle();
      checkOutput("bp drain valid", 64'(outValid), 64'd0);

      // Flush with 3 queued entries and a valid output
      applyStimulus(3'd0);
      applyStimulus(3'd1);
      applyStimulus(3'd2);
      applyStimulus(3'd3);
      outReady = 1'b0;
      inResult[0] = 64'h05; inStatus[0] = 5'b10101; inValid = 5'b00001;
      nextCycle();
      inValid = '0;
      checkOutput("fl pre count", 64'(count), 64'd3);
      checkOutput("fl pre valid", 64'(outValid), 64'd1);
      checkOutput("fl pre status", 64'(status), 64'b10101);
      flush = 1'b1; issueValid = 1'b1; issueIdx = 3'd1;
      #1;
      checkOutput("fl issueReady", 64'(issueReady), 64'd0);
      nextCycle();
      flush = 1'b0; issueValid = 1'b0;
      checkOutput("fl count", 64'(count), 64'd0);
      checkOutput("fl valid", 64'(outValid), 64'd0);
      checkOutput("fl busy", 64'(busy), 64'd0);

      // Asynchronous reset mid-run
      outReady = 1'b1;
      applyStimulus(3'd3);
      applyStimulus(3'd2);
      checkOutput("mr count", 64'(count), 64'd2);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("mr rst count", 64'(count), 64'd0);
      checkOutput("mr rst result", result, 64'd0);
      checkOutput("mr rst busy", 64'(busy), 64'd0);
      checkOutput("mr rst issueReady", 64'(issueReady), 64'd1);
      checkOutput("mr rst inReady", 64'(inReady), 64'd0);
      nextCycle();
      rst = 1'b0;
      applyStimulus(3'd2);
      inResult[2] = 64'h77; inTag[2] = 1'b1; inValid = 5'b00100;
      #1;
      checkOutput("mr head ready", 64'(inReady), 64'b00100);
      nextCycle();
      inValid = '0;
      checkOutput("mr out valid", 64'(outValid), 64'd1);
      checkOutput("mr out result", result, 64'h77);
      checkOutput("mr out tag", 64'(tag), 64'd1);
      checkOutput("mr out count", 64'(count), 64'd0);

      // Pass-through instance: 10 back-to-back ops through a depth-3 queue
      issueValid2 = 1'b1;
      nextCycle();
      checkOutput("pt prime count", 64'(count2), 64'd1);
      for (int k = 0; k < 10; k++) begin
         issueValid2  = (k < 9);
         inValid2     = 1'b1;
         inResult2[0] = 16'h100 + 16'(k);
         inStatus2[0] = 5'(k * 7);
         inTag2[0]    = 1'(k);
         #1;
         checkOutput("pt valid", 64'(outValid2), 64'd1);
         checkOutput("pt result", 64'(result2), 64'h100 + 64'(k));
         checkOutput("pt status", 64'(status2), 64'((k * 7) % 32));
         checkOutput("pt tag", 64'(tag2), 64'(k % 2));
         nextCycle();
         checkOutput("pt count", 64'(count2), (k < 9) ? 64'd1 : 64'd0);
      end
      issueValid2 = 1'b0;
      inValid2 = 1'b0;
      #1;
      checkOutput("pt idle valid", 64'(outValid2), 64'd0);
      checkOutput("pt idle busy", 64'(busy2), 64'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
